// File: rtl/digital_input_filter_if.sv
// Bus bundle between the pin-stage readback and the input filter.
// Master drives raw levels and controls; slave returns filtered state.
interface digital_input_filter_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_flag;
  logic             irq;

  modport master (
    output en, raw_in, clear, irq_mask,
    input  filt_out, rise, fall, event_flag, irq
  );

  modport slave (
    input  en, raw_in, clear, irq_mask,
    output filt_out, rise, fall, event_flag, irq
  );
endinterface

// File: rtl/digital_input_filter.sv
// Per-channel sync + debounce + edge pulses for PLC digital inputs,
// with sticky event flags and a maskable interrupt.
module digital_input_filter #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4,
  parameter int EDGE_SEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digital_input_filter_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(DEBOUNCE - 1);
  localparam bit LP_RISE = (EDGE_SEL != 1);
  localparam bit LP_FALL = (EDGE_SEL != 0);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_flag;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_filt_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_flag_nxt;

  // Count only sample ticks where the synced level disagrees
  always_comb begin
    w_filt_nxt = r_filt;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (bus.en) begin
        if (r_sync2[i] == r_filt[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] >= LP_TOP) begin
          w_cnt_nxt[i]  = '0;
          w_filt_nxt[i] = r_sync2[i];
          w_rise_nxt[i] = r_sync2[i];
          w_fall_nxt[i] = ~r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set beats clear when both land on the same edge
  always_comb begin
    w_set = ({WIDTH{LP_RISE}} & w_rise_nxt)
          | ({WIDTH{LP_FALL}} & w_fall_nxt);
    w_flag_nxt = (r_flag & ~bus.clear) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_flag  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
      r_filt  <= w_filt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_flag  <= w_flag_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.filt_out   = r_filt;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.event_flag = r_flag;
  assign bus.irq        = |(r_flag & bus.irq_mask);

endmodule
